fsic_io_serdes_tx: RTL and testbench

Transmit-side serializer for the FSIC inter-chip IO link, and the far-end partner of the serdes receiver.
- Accepts pCLK_RATIO-bit parallel words through a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out LSB-first, one bit per ioclk, as a continuous word-aligned stream.
- Inserts a fixed idle word whenever no data is buffered, so that word alignment at the receiver is never lost.

---
 rtl/fsic_io_serdes_tx.sv | 140 ++++++++++++++
 tb/tb_fsic_io_serdes_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsic_io_serdes_tx.sv
// Transmit serializer for the FSIC IO link: buffers parallel words in a small FIFO
// and shifts them out LSB-first, filling empty word slots with an idle word.
module fsic_io_serdes_tx #(
   parameter int                    pCLK_RATIO    = 4,
   parameter int                    pTxFIFO_DEPTH = 4,
   parameter logic [pCLK_RATIO-1:0] pIDLE_WORD    = '0
) (
   input  logic                  ioclk,
   input  logic                  axis_rst_n,
   input  logic                  txen,
   input  logic [pCLK_RATIO-1:0] txdata_in,
   input  logic                  txdata_in_valid,
   output logic                  txdata_in_ready,
   output logic                  Serial_Data_out,
   output logic                  tx_busy,
   output logic                  tx_underflow
);

   localparam int CW  = $clog2(pTxFIFO_DEPTH + 1);
   localparam int PW  = $clog2(pTxFIFO_DEPTH);
   localparam int PHW = $clog2(pCLK_RATIO);

   localparam logic [CW-1:0]  DEPTH_C    = CW'(pTxFIFO_DEPTH);
   localparam logic [PW-1:0]  LAST_PTR   = PW'(pTxFIFO_DEPTH - 1);
   localparam logic [PHW-1:0] LAST_PHASE = PHW'(pCLK_RATIO - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                state_q;
   logic [pCLK_RATIO-1:0] fifo_mem_q [pTxFIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [pCLK_RATIO-1:0] shift_q;
   logic [PHW-1:0]        phase_q;
   logic                  underflow_q;

   logic                  fifo_empty;
   logic                  push;
   logic                  load;
   logic                  pop;
   logic [pCLK_RATIO-1:0] load_word;

   // Handshake: a word transfers on any posedge where txdata_in_valid && txdata_in_ready;
   // ready depends on the FIFO fill level only, never on valid.
   always_comb begin
      fifo_empty      = (count_q == '0);
      txdata_in_ready = (count_q != DEPTH_C);
      push            = txdata_in_valid && txdata_in_ready;
      load            = txen && ((state_q == ST_IDLE) || (phase_q == LAST_PHASE));
      pop             = load && !fifo_empty;
      load_word       = fifo_empty ? pIDLE_WORD : fifo_mem_q[rd_ptr_q];

      wr_ptr_d = wr_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      end
      rd_ptr_d = rd_ptr_q;
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      end

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset: a cleared count makes stale entries unreachable.
   always_ff @(posedge ioclk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= txdata_in;
      end
   end

   always_ff @(posedge ioclk) begin
      if (!axis_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge ioclk) begin
      if (!axis_rst_n) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         phase_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               phase_q <= '0;
               if (txen) begin
                  shift_q <= load_word;
                  state_q <= ST_SHIFT;
                  if (fifo_empty) underflow_q <= 1'b1;
               end else begin
                  shift_q     <= '0;
                  underflow_q <= 1'b0;
               end
            end
            ST_SHIFT: begin
               // txen only matters on the last bit, so a word is never cut short.
               if (phase_q != LAST_PHASE) begin
                  shift_q <= {1'b0, shift_q[pCLK_RATIO-1:1]};
                  phase_q <= phase_q + PHW'(1);
               end else if (txen) begin
                  shift_q <= load_word;
                  phase_q <= '0;
                  if (fifo_empty) underflow_q <= 1'b1;
               end else begin
                  shift_q <= '0;
                  phase_q <= '0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               shift_q <= '0;
               phase_q <= '0;
            end
         endcase
      end
   end

   assign Serial_Data_out = shift_q[0];
   assign tx_busy         = (state_q == ST_SHIFT);
   assign tx_underflow    = underflow_q;

endmodule

// File: tb/tb_fsic_io_serdes_tx.sv
// Bench for fsic_io_serdes_tx: vector table, directed corner sequences, and a random
// run compared every cycle against a word/bit-queue model of the link.
module tb_fsic_io_serdes_tx;
   localparam int            R     = 4;
   localparam int            DEPTH = 4;
   localparam logic [R-1:0]  IDLE  = '0;

   logic          ioclk = 1'b0;
   logic          axis_rst_n = 1'b0;
   logic          txen = 1'b0;
   logic [R-1:0]  txdata_in = '0;
   logic          txdata_in_valid = 1'b0;
   logic          txdata_in_ready;
   logic          Serial_Data_out;
   logic          tx_busy;
   logic          tx_underflow;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   fsic_io_serdes_tx #(
      .pCLK_RATIO   (R),
      .pTxFIFO_DEPTH(DEPTH),
      .pIDLE_WORD   (IDLE)
   ) dut (
      .ioclk          (ioclk),
      .axis_rst_n     (axis_rst_n),
      .txen           (txen),
      .txdata_in      (txdata_in),
      .txdata_in_valid(txdata_in_valid),
      .txdata_in_ready(txdata_in_ready),
      .Serial_Data_out(Serial_Data_out),
      .tx_busy        (tx_busy),
      .tx_underflow   (tx_underflow)
   );

   always #5 ioclk = ~ioclk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ioclk);
      #1;
   endtask

   // Reference model: queue of buffered words plus the bits still to go out of the
   // word on the wire; a new word is taken only when the last bit has been shown.
   logic [R-1:0] m_fifo[$];
   bit           m_bits[$];
   bit           m_busy = 1'b0;
   bit           m_uf   = 1'b0;

   always @(posedge ioclk) begin
      bit           was_full;
      logic [R-1:0] w;
      if (!axis_rst_n) begin
         m_fifo.delete();
         m_bits.delete();
         m_busy = 1'b0;
         m_uf   = 1'b0;
      end else begin
         was_full = (m_fifo.size() == DEPTH);
         if (m_busy && m_bits.size() > 1) begin
            void'(m_bits.pop_front());
         end else if (txen) begin
            if (m_fifo.size() > 0) begin
               w = m_fifo.pop_front();
            end else begin
               w = IDLE;
               m_uf = 1'b1;
            end
            m_bits.delete();
            for (int i = 0; i < R; i++) m_bits.push_back(w[i]);
            m_busy = 1'b1;
         end else begin
            if (!m_busy) m_uf = 1'b0;
            m_bits.delete();
            m_busy = 1'b0;
         end
         if (txdata_in_valid && !was_full) m_fifo.push_back(txdata_in);
      end
   end

   always @(negedge ioclk) begin
      if (mon_en) begin
         check("mon_ser",   {7'd0, Serial_Data_out}, {7'd0, (m_busy ? m_bits[0] : 1'b0)});
         check("mon_busy",  {7'd0, tx_busy},         {7'd0, m_busy});
         check("mon_ready", {7'd0, txdata_in_ready}, {7'd0, (m_fifo.size() < DEPTH)});
         check("mon_uf",    {7'd0, tx_underflow},    {7'd0, m_uf});
      end
   end

   typedef struct packed {
      logic         rst_n;
      logic         en;
      logic         valid;
      logic [R-1:0] data;
      logic         ser;
      logic         busy;
      logic         rdy;
      logic         uf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic e, input logic v, input logic [R-1:0] d,
                      input logic s, input logic b, input logic rd, input logic u);
      vec_t x;
      x.rst_n = r; x.en = e; x.valid = v; x.data = d;
      x.ser = s; x.busy = b; x.rdy = rd; x.uf = u;
      vecs.push_back(x);
   endtask

   task automatic do_reset();
      axis_rst_n = 1'b0;
      txen = 1'b0;
      txdata_in_valid = 1'b0;
      step();
      axis_rst_n = 1'b1;
   endtask

   task automatic push_word(input logic [R-1:0] d);
      txdata_in = d;
      txdata_in_valid = 1'b1;
      step();
      txdata_in_valid = 1'b0;
   endtask

   // Positioned just after a load edge; samples one whole word with txen held high.
   task automatic check_word(input string name, input logic [R-1:0] exp);
      logic [R-1:0] w;
      for (int i = 0; i < R; i++) begin
         w[i] = Serial_Data_out;
         step();
      end
      check(name, {4'd0, w}, {4'd0, exp});
   endtask

   initial begin
      // basic serialization of 0xA then 0x5
      add(0, 0, 0, 4'h0, 0, 0, 1, 0);
      add(1, 0, 1, 4'hA, 0, 0, 1, 0);
      add(1, 0, 1, 4'h5, 0, 0, 1, 0);
      add(1, 1, 0, 4'h0, 0, 1, 1, 0);
      add(1, 1, 0, 4'h0, 1, 1, 1, 0);
      add(1, 1, 0, 4'h0, 0, 1, 1, 0);
      add(1, 1, 0, 4'h0, 1, 1, 1, 0);
      add(1, 1, 0, 4'h0, 1, 1, 1, 0);
      add(1, 1, 0, 4'h0, 0, 1, 1, 0);
      add(1, 1, 0, 4'h0, 1, 1, 1, 0);
      add(1, 0, 0, 4'h0, 0, 1, 1, 0);
      add(1, 0, 0, 4'h0, 0, 0, 1, 0);
      add(1, 0, 0, 4'h0, 0, 0, 1, 0);
      // backpressure: four words fill the FIFO, the fifth is refused
      add(0, 0, 0, 4'h0, 0, 0, 1, 0);
      add(1, 0, 1, 4'h1, 0, 0, 1, 0);
      add(1, 0, 1, 4'h2, 0, 0, 1, 0);
      add(1, 0, 1, 4'h3, 0, 0, 1, 0);
      add(1, 0, 1, 4'h4, 0, 0, 0, 0);
      add(1, 0, 1, 4'h5, 0, 0, 0, 0);
      add(1, 1, 0, 4'h0, 1, 1, 1, 0);

      axis_rst_n = 1'b0;
      step();
      step();
      mon_en = 1'b1;

      foreach (vecs[k]) begin
         axis_rst_n      = vecs[k].rst_n;
         txen            = vecs[k].en;
         txdata_in_valid = vecs[k].valid;
         txdata_in       = vecs[k].data;
         step();
         check($sformatf("vec%0d_ser", k),   {7'd0, Serial_Data_out}, {7'd0, vecs[k].ser});
         check($sformatf("vec%0d_busy", k),  {7'd0, tx_busy},         {7'd0, vecs[k].busy});
         check($sformatf("vec%0d_ready", k), {7'd0, txdata_in_ready}, {7'd0, vecs[k].rdy});
         check($sformatf("vec%0d_uf", k),    {7'd0, tx_underflow},    {7'd0, vecs[k].uf});
      end
      txen = 1'b1;
      check_word("bp_word1", 4'h1);
      check_word("bp_word2", 4'h2);
      check_word("bp_word3", 4'h3);
      check_word("bp_word4", 4'h4);
      check("bp_idle_uf", {7'd0, tx_underflow}, 8'd1);

      // underflow: empty FIFO, txen high for two words
      do_reset();
      txen = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("uf_bit%0d", i), {7'd0, Serial_Data_out}, 8'd0);
         check($sformatf("uf_flag%0d", i), {7'd0, tx_underflow}, 8'd1);
      end
      txen = 1'b0;
      step();
      check("uf_stop_busy", {7'd0, tx_busy}, 8'd0);
      check("uf_still_set", {7'd0, tx_underflow}, 8'd1);
      step();
      check("uf_cleared", {7'd0, tx_underflow}, 8'd0);

      // stop mid-word: the word still completes
      do_reset();
      push_word(4'hF);
      txen = 1'b1;
      step();
      check("stop_p0", {7'd0, Serial_Data_out}, 8'd1);
      step();
      check("stop_p1", {7'd0, Serial_Data_out}, 8'd1);
      txen = 1'b0;
      step();
      check("stop_p2", {7'd0, Serial_Data_out}, 8'd1);
      step();
      check("stop_p3", {7'd0, Serial_Data_out}, 8'd1);
      check("stop_p3_busy", {7'd0, tx_busy}, 8'd1);
      step();
      check("stop_end_ser", {7'd0, Serial_Data_out}, 8'd0);
      check("stop_end_busy", {7'd0, tx_busy}, 8'd0);

      // push and pop on the same edge
      do_reset();
      push_word(4'h1);
      push_word(4'h2);
      push_word(4'h3);
      txen = 1'b1;
      txdata_in = 4'h7;
      txdata_in_valid = 1'b1;
      step();
      txdata_in_valid = 1'b0;
      check("pp_ready", {7'd0, txdata_in_ready}, 8'd1);
      check_word("pp_word1", 4'h1);
      check_word("pp_word2", 4'h2);
      check_word("pp_word3", 4'h3);
      check("pp_no_uf", {7'd0, tx_underflow}, 8'd0);
      check_word("pp_word7", 4'h7);
      check("pp_then_idle", {7'd0, tx_underflow}, 8'd1);

      // reset in the middle of a word with data buffered
      do_reset();
      push_word(4'h1);
      push_word(4'h2);
      push_word(4'h3);
      txen = 1'b1;
      step();
      step();
      step();
      axis_rst_n = 1'b0;
      step();
      check("rst_ser", {7'd0, Serial_Data_out}, 8'd0);
      check("rst_busy", {7'd0, tx_busy}, 8'd0);
      check("rst_ready", {7'd0, txdata_in_ready}, 8'd1);
      check("rst_uf", {7'd0, tx_underflow}, 8'd0);
      axis_rst_n = 1'b1;
      txen = 1'b0;
      step();
      txen = 1'b1;
      step();
      check("rst_empty_uf", {7'd0, tx_underflow}, 8'd1);
      check("rst_empty_ser", {7'd0, Serial_Data_out}, 8'd0);
      txen = 1'b0;

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         axis_rst_n      = ($urandom_range(0, 199) != 0);
         txen            = ($urandom_range(0, 9) < 7);
         txdata_in_valid = ($urandom_range(0, 9) < 6);
         txdata_in       = R'($urandom);
         step();
      end
      txen = 1'b0;
      txdata_in_valid = 1'b0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
